// File: rtl/snn_pkg.sv
// Shared SNN packet layout constants and the adder-node state encoding.
// Packets are {source address, pad, type, payload}, with the payload right-aligned.
package snn_pkg;

    localparam int SRC_W  = 4;
    localparam int PAD_W  = 4;
    localparam int TYPE_W = 2;
    localparam int HDR_W  = SRC_W + PAD_W + TYPE_W;

    localparam logic [TYPE_W-1:0] MP_TYPE    = 2'b10;
    localparam logic [TYPE_W-1:0] SPIKE_TYPE = 2'b11;
    localparam logic [3:0]        DONE_CODE  = 4'hF;

    localparam logic [SRC_W-1:0] DEFAULT_ADDER_ADDR = 4'b0110;
    localparam logic [PAD_W-1:0] HDR_PAD            = '0;

    typedef enum logic [2:0] {
        COLLECT,
        ACCUM,
        SEND_MP,
        SEND_SPIKE,
        SEND_DONE
    } state_t;

endpackage

// File: rtl/psum_sat_adder.sv
// Combinational leak of a stored membrane potential followed by a NUM_PE-input
// partial-sum addition, saturated back to MP_WIDTH bits.
module psum_sat_adder
    import snn_pkg::*;
#(
    parameter int          MP_WIDTH = 8,
    parameter int          NUM_PE   = 5,
    parameter int unsigned LEAK     = 0
) (
    input  logic [MP_WIDTH-1:0]        mp_i,
    input  logic [NUM_PE*MP_WIDTH-1:0] psums_i,
    output logic [MP_WIDTH-1:0]        sum_o
);

    // Wide enough for NUM_PE+1 full-scale operands, so the sum itself never wraps.
    localparam int SUM_W = MP_WIDTH + $clog2(NUM_PE + 1);
    localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-MP_WIDTH){1'b0}}, {MP_WIDTH{1'b1}}};

    logic [MP_WIDTH-1:0] leaked;
    logic [SUM_W-1:0]    total;

    always_comb begin
        leaked = '0;
        if (32'(mp_i) > LEAK) begin
            leaked = MP_WIDTH'(32'(mp_i) - LEAK);
        end
        total = SUM_W'(leaked);
        for (int i = 0; i < NUM_PE; i++) begin
            total = total + SUM_W'(psums_i[i*MP_WIDTH +: MP_WIDTH]);
        end
        sum_o = (total > SAT_MAX) ? {MP_WIDTH{1'b1}} : total[MP_WIDTH-1:0];
    end

endmodule

// File: rtl/partial_sum_accum.sv
// Collects NUM_PE partial sums per neuron, integrates them into locally held
// membrane potentials and emits MP / spike / done packets over valid/ready.
module partial_sum_accum
    import snn_pkg::*;
#(
    parameter int          WIDTH       = 64,
    parameter int          MP_WIDTH    = 8,
    parameter int          NUM_PE      = 5,
    parameter int          NUM_NEURONS = 5,
    parameter int unsigned THRESHOLD   = 16,
    parameter int unsigned LEAK        = 0,
    parameter int          RESET_MODE  = 0,
    parameter int          ADDER_NUM   = 0,
    parameter int          ADDER_COUNT = 4,
    parameter logic [3:0]  ADDER_ADDR  = DEFAULT_ADDER_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             clear_mp,
    output logic             busy,
    output logic             err_dup
);

    localparam int CNT_W   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int PAY_W   = WIDTH - HDR_W;
    localparam bit IS_LAST = (ADDER_NUM == ADDER_COUNT);

    state_t                     state_q, state_d;
    logic [NUM_PE-1:0]          bitmap_q, bitmap_d;
    logic [NUM_PE*MP_WIDTH-1:0] psum_q, psum_d;
    logic [MP_WIDTH-1:0]        mp_q [NUM_NEURONS];
    logic [MP_WIDTH-1:0]        mp_d [NUM_NEURONS];
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       fire_q, fire_d;
    logic                       errDup_q, errDup_d;
    logic                       clearPend_q, clearPend_d;
    logic [WIDTH-1:0]           outData_q, outData_d;

    logic [MP_WIDTH-1:0]           sumSat, newMp;
    logic                          fire, inHs, clearReq, leaving;
    logic [SRC_W-1:0]              src;
    logic [2:0]                    countLow;
    logic [WIDTH-SRC_W-MP_WIDTH-1:0] unusedInData;

    function automatic logic [WIDTH-1:0] makePacket(input logic [TYPE_W-1:0] pktType,
                                                    input logic [PAY_W-1:0]  payload);
        return {ADDER_ADDR, HDR_PAD, pktType, payload};
    endfunction

    assign src          = in_data[WIDTH-1 -: SRC_W];
    assign unusedInData = in_data[WIDTH-SRC_W-1:MP_WIDTH];
    assign countLow     = 3'(count_q);
    assign in_ready     = (state_q == COLLECT);
    assign out_valid    = (state_q == SEND_MP) || (state_q == SEND_SPIKE) || (state_q == SEND_DONE);
    assign out_data     = outData_q;
    assign err_dup      = errDup_q;
    assign busy         = !((state_q == COLLECT) && (bitmap_q == '0));
    assign inHs         = in_valid && in_ready;
    assign clearReq     = clear_mp || clearPend_q;

    psum_sat_adder #(
        .MP_WIDTH (MP_WIDTH),
        .NUM_PE   (NUM_PE),
        .LEAK     (LEAK)
    ) uAdder (
        .mp_i    (mp_q[count_q]),
        .psums_i (psum_q),
        .sum_o   (sumSat)
    );

    always_comb begin
        fire  = (32'(sumSat) >= THRESHOLD);
        newMp = sumSat;
        if (fire) begin
            newMp = (RESET_MODE != 0) ? '0 : MP_WIDTH'(32'(sumSat) - THRESHOLD);
        end
    end

    // Next-state logic; a clear that arrives mid-transaction is parked in clearPend until the node is idle again.
    always_comb begin
        state_d     = state_q;
        bitmap_d    = bitmap_q;
        psum_d      = psum_q;
        mp_d        = mp_q;
        count_d     = count_q;
        fire_d      = fire_q;
        errDup_d    = errDup_q;
        clearPend_d = clearPend_q;
        outData_d   = outData_q;
        leaving     = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (clearReq) begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        mp_d[i] = '0;
                    end
                    count_d     = '0;
                    bitmap_d    = '0;
                    clearPend_d = 1'b0;
                end else if (inHs) begin
                    if (32'(src) < NUM_PE) begin
                        for (int i = 0; i < NUM_PE; i++) begin
                            if (32'(src) == i) begin
                                if (bitmap_q[i]) begin
                                    errDup_d = 1'b1;
                                end
                                bitmap_d[i] = 1'b1;
                                psum_d[i*MP_WIDTH +: MP_WIDTH] = in_data[MP_WIDTH-1:0];
                            end
                        end
                    end else begin
                        errDup_d = 1'b1;
                    end
                    if (&bitmap_d) begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                mp_d[count_q] = newMp;
                fire_d        = fire;
                outData_d     = makePacket(MP_TYPE, PAY_W'(newMp));
                state_d       = SEND_MP;
            end
            SEND_MP: begin
                if (out_ready) begin
                    if (fire_q) begin
                        state_d   = SEND_SPIKE;
                        outData_d = makePacket(SPIKE_TYPE, PAY_W'({countLow, 3'(ADDER_NUM)}));
                    end else if (IS_LAST) begin
                        state_d   = SEND_DONE;
                        outData_d = makePacket(SPIKE_TYPE, PAY_W'(DONE_CODE));
                    end else begin
                        leaving = 1'b1;
                    end
                end
            end
            SEND_SPIKE: begin
                if (out_ready) begin
                    if (IS_LAST) begin
                        state_d   = SEND_DONE;
                        outData_d = makePacket(SPIKE_TYPE, PAY_W'(DONE_CODE));
                    end else begin
                        leaving = 1'b1;
                    end
                end
            end
            SEND_DONE: begin
                if (out_ready) begin
                    leaving = 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        if ((state_q != COLLECT) && clear_mp) begin
            clearPend_d = 1'b1;
        end

        if (leaving) begin
            state_d   = COLLECT;
            bitmap_d  = '0;
            fire_d    = 1'b0;
            outData_d = '0;
            if (clearReq) begin
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    mp_d[i] = '0;
                end
                count_d     = '0;
                clearPend_d = 1'b0;
            end else begin
                count_d = (32'(count_q) == NUM_NEURONS - 1) ? '0 : count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            bitmap_q    <= '0;
            psum_q      <= '0;
            count_q     <= '0;
            fire_q      <= 1'b0;
            errDup_q    <= 1'b0;
            clearPend_q <= 1'b0;
            outData_q   <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mp_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bitmap_q    <= bitmap_d;
            psum_q      <= psum_d;
            count_q     <= count_d;
            fire_q      <= fire_d;
            errDup_q    <= errDup_d;
            clearPend_q <= clearPend_d;
            outData_q   <= outData_d;
            mp_q        <= mp_d;
        end
    end

endmodule

// File: tb/tb_partial_sum_accum.sv
// Directed self-checking bench: three adder configurations (default, last-adder
// with reset-to-zero, and leaky) driven from a vector table plus corner sequences.
`timescale 1ns/1ps
module tb_partial_sum_accum;

    logic        clk;
    logic        rst      [3];
    logic        inValid  [3];
    logic        inReady  [3];
    logic [63:0] inData   [3];
    logic        outValid [3];
    logic        outReady [3];
    logic [63:0] outData  [3];
    logic        clearMp  [3];
    logic        busy     [3];
    logic        errDup   [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        logic [39:0] psums;
        logic [7:0]  expMp;
        bit          expFire;
        logic [7:0]  expSpike;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    partial_sum_accum dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
        .clear_mp(clearMp[0]), .busy(busy[0]), .err_dup(errDup[0])
    );

    partial_sum_accum #(.RESET_MODE(1), .ADDER_NUM(4)) dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
        .clear_mp(clearMp[1]), .busy(busy[1]), .err_dup(errDup[1])
    );

    partial_sum_accum #(.LEAK(3)) dut2 (
        .clk(clk), .rst(rst[2]), .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .out_data(outData[2]),
        .clear_mp(clearMp[2]), .busy(busy[2]), .err_dup(errDup[2])
    );

    function automatic logic [63:0] expPkt(input logic [1:0] t, input logic [15:0] p);
        logic [63:0] k;
        k          = '0;
        k[63:60]   = 4'b0110;
        k[55:54]   = t;
        k[15:0]    = p;
        return k;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [3:0] src, input logic [7:0] val);
        int w;
        w = 0;
        @(negedge clk);
        inData[d]  = {src, 52'b0, val};
        inValid[d] = 1'b1;
        while (inReady[d] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput($sformatf("dut%0d.inReady", d), 64'(inReady[d]), 64'd1);
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
    endtask

    task automatic sendNeuron(input int d, input logic [39:0] psums);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(d, 4'(i), psums[i*8 +: 8]);
        end
    endtask

    task automatic expectPacket(input int d, input string name, input logic [63:0] exp, input int maxWait);
        int w;
        w = 0;
        @(negedge clk);
        while (outValid[d] !== 1'b1 && w < maxWait) begin
            @(negedge clk);
            w++;
        end
        checkOutput({name, ".valid"}, 64'(outValid[d]), 64'd1);
        checkOutput(name, outData[d], exp);
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input int d);
        int w;
        w = 0;
        @(negedge clk);
        while (outValid[d] !== 1'b1 && w < 5) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic runNeuron(input int d, input logic [39:0] psums, input logic [7:0] expMp,
                             input bit expFire, input logic [7:0] expSpike, input string tag);
        sendNeuron(d, psums);
        @(negedge clk);
        checkOutput({tag, ".accumGap"}, 64'(outValid[d]), 64'd0);
        expectPacket(d, {tag, ".mp"}, expPkt(2'b10, {8'h00, expMp}), 0);
        if (expFire) expectPacket(d, {tag, ".spike"}, expPkt(2'b11, {8'h00, expSpike}), 0);
        if (d == 1) expectPacket(d, {tag, ".done"}, expPkt(2'b11, 16'h000F), 0);
        @(negedge clk);
        checkOutput({tag, ".idle"}, 64'(outValid[d]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // dut0: defaults; dut1: RESET_MODE=1 and last adder; dut2: LEAK=3
        vecs[0]  = '{dut:0, psums:40'h0504030201, expMp:8'd15,  expFire:1'b0, expSpike:8'd0};
        vecs[1]  = '{dut:0, psums:40'hFFFFFFFFFF, expMp:8'd239, expFire:1'b1, expSpike:8'd8};
        vecs[2]  = '{dut:0, psums:40'h0000000000, expMp:8'd0,   expFire:1'b0, expSpike:8'd0};
        vecs[3]  = '{dut:0, psums:40'h0000000010, expMp:8'd0,   expFire:1'b1, expSpike:8'd24};
        vecs[4]  = '{dut:0, psums:40'h000000000F, expMp:8'd15,  expFire:1'b0, expSpike:8'd0};
        vecs[5]  = '{dut:0, psums:40'h0000000002, expMp:8'd1,   expFire:1'b1, expSpike:8'd0};
        vecs[6]  = '{dut:0, psums:40'h000000000A, expMp:8'd233, expFire:1'b1, expSpike:8'd8};
        vecs[7]  = '{dut:1, psums:40'h0504030201, expMp:8'd15,  expFire:1'b0, expSpike:8'd0};
        vecs[8]  = '{dut:1, psums:40'h0000000011, expMp:8'd0,   expFire:1'b1, expSpike:8'd12};
        vecs[9]  = '{dut:2, psums:40'h0000000002, expMp:8'd2,   expFire:1'b0, expSpike:8'd0};
        vecs[10] = '{dut:2, psums:40'h000000000A, expMp:8'd10,  expFire:1'b0, expSpike:8'd0};
        vecs[11] = '{dut:2, psums:40'h0000000000, expMp:8'd0,   expFire:1'b0, expSpike:8'd0};
        vecs[12] = '{dut:2, psums:40'h0000000000, expMp:8'd0,   expFire:1'b0, expSpike:8'd0};
        vecs[13] = '{dut:2, psums:40'h0000000000, expMp:8'd0,   expFire:1'b0, expSpike:8'd0};
        vecs[14] = '{dut:2, psums:40'h0000000001, expMp:8'd1,   expFire:1'b0, expSpike:8'd0};
        vecs[15] = '{dut:2, psums:40'h0000000000, expMp:8'd7,   expFire:1'b0, expSpike:8'd0};

        for (int d = 0; d < 3; d++) begin
            rst[d]      = 1'b1;
            inValid[d]  = 1'b0;
            inData[d]   = '0;
            outReady[d] = 1'b1;
            clearMp[d]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset%0d.outValid", d), 64'(outValid[d]), 64'd0);
            checkOutput($sformatf("reset%0d.inReady", d), 64'(inReady[d]), 64'd1);
            checkOutput($sformatf("reset%0d.outData", d), outData[d], 64'd0);
            checkOutput($sformatf("reset%0d.errDup", d), 64'(errDup[d]), 64'd0);
            checkOutput($sformatf("reset%0d.busy", d), 64'(busy[d]), 64'd0);
        end

        for (int i = 0; i < NV; i++) begin
            runNeuron(vecs[i].dut, vecs[i].psums, vecs[i].expMp, vecs[i].expFire,
                      vecs[i].expSpike, $sformatf("vec%0d", i));
        end

        // dut0 neuron 2: duplicate PE1 (7 then 9), out-of-range src 12 dropped
        applyStimulus(0, 4'd0, 8'd1);
        checkOutput("dup.busyPartial", 64'(busy[0]), 64'd1);
        checkOutput("dup.errBefore", 64'(errDup[0]), 64'd0);
        applyStimulus(0, 4'd1, 8'd7);
        applyStimulus(0, 4'd1, 8'd9);
        checkOutput("dup.errSet", 64'(errDup[0]), 64'd1);
        applyStimulus(0, 4'd12, 8'd99);
        checkOutput("dup.errSticky", 64'(errDup[0]), 64'd1);
        applyStimulus(0, 4'd2, 8'd0);
        applyStimulus(0, 4'd3, 8'd0);
        applyStimulus(0, 4'd4, 8'd0);
        @(negedge clk);
        checkOutput("dup.accumGap", 64'(outValid[0]), 64'd0);
        expectPacket(0, "dup.mp", expPkt(2'b10, 16'd10), 0);
        @(negedge clk);
        checkOutput("dup.idle", 64'(outValid[0]), 64'd0);

        // dut0 neuron 3: clear_mp during SEND_MP must wait for the packet to go out
        outReady[0] = 1'b0;
        sendNeuron(0, 40'h0000000005);
        waitValid(0);
        checkOutput("clr.mpBefore", outData[0], expPkt(2'b10, 16'd5));
        clearMp[0] = 1'b1;
        @(posedge clk);
        #1;
        clearMp[0] = 1'b0;
        @(negedge clk);
        checkOutput("clr.validHeld", 64'(outValid[0]), 64'd1);
        checkOutput("clr.mpHeld", outData[0], expPkt(2'b10, 16'd5));
        outReady[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("clr.idle", 64'(outValid[0]), 64'd0);
        runNeuron(0, 40'h0000000003, 8'd3, 1'b0, 8'd0, "postClear");

        // dut0 neuron 1: reset while the spike packet is on the bus
        sendNeuron(0, 40'h0000000014);
        @(negedge clk);
        checkOutput("rst.accumGap", 64'(outValid[0]), 64'd0);
        expectPacket(0, "rst.mp", expPkt(2'b10, 16'd4), 0);
        @(negedge clk);
        checkOutput("rst.spikeValid", 64'(outValid[0]), 64'd1);
        checkOutput("rst.spike", outData[0], expPkt(2'b11, 16'd8));
        outReady[0] = 1'b0;
        rst[0]      = 1'b1;
        @(posedge clk);
        #1;
        rst[0]      = 1'b0;
        outReady[0] = 1'b1;
        @(negedge clk);
        checkOutput("rst.outValid", 64'(outValid[0]), 64'd0);
        checkOutput("rst.errDup", 64'(errDup[0]), 64'd0);
        checkOutput("rst.inReady", 64'(inReady[0]), 64'd1);
        checkOutput("rst.busy", 64'(busy[0]), 64'd0);
        checkOutput("rst.outData", outData[0], 64'd0);
        runNeuron(0, 40'h0000000004, 8'd4, 1'b0, 8'd0, "postRst");

        // dut1 neuron 2: stall the MP packet, then MP/SPIKE/DONE back to back
        outReady[1] = 1'b0;
        sendNeuron(1, 40'h0000000014);
        waitValid(1);
        checkOutput("stall.mp", outData[1], expPkt(2'b10, 16'd0));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stall.hold%0d.valid", c), 64'(outValid[1]), 64'd1);
            checkOutput($sformatf("stall.hold%0d.data", c), outData[1], expPkt(2'b10, 16'd0));
        end
        outReady[1] = 1'b1;
        @(posedge clk);
        #1;
        expectPacket(1, "stall.spike", expPkt(2'b11, 16'h0014), 0);
        expectPacket(1, "stall.done", expPkt(2'b11, 16'h000F), 0);
        @(negedge clk);
        checkOutput("stall.idle", 64'(outValid[1]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
